// File: rtl/mem_tile_l2_bank_if.sv
// mem_tile_l2_bank_if
// Request/response channel between a D-tile (master) and one NUCA L2 bank
// (slave).
//   mem_tile_addr         : request byte address
//   mem_tile_read_req     : line read request
//   mem_tile_write_req    : line write request
//   mem_tile_wr_data_wide : write line, word 0 = lowest addressed 8 bytes
//   mem_tile_config_srf   : scratchpad (SRF) mode, sampled per request
//   req_ready             : bank can accept a request this cycle
//   mem_tile_ack          : single-cycle completion pulse
//   mem_tile_rd_data_wide : read line, valid with ack on a read
//   busy                  : bank has queued or in-flight work
//   proto_err             : sticky, read and write requested together
interface mem_tile_l2_bank_if;
    logic [31:0]      mem_tile_addr;
    logic             mem_tile_read_req;
    logic             mem_tile_write_req;
    logic [3:0][63:0] mem_tile_wr_data_wide;
    logic             mem_tile_config_srf;
    logic             req_ready;
    logic             mem_tile_ack;
    logic [3:0][63:0] mem_tile_rd_data_wide;
    logic             busy;
    logic             proto_err;

    modport master (
        output mem_tile_addr, mem_tile_read_req, mem_tile_write_req,
               mem_tile_wr_data_wide, mem_tile_config_srf,
        input  req_ready, mem_tile_ack, mem_tile_rd_data_wide, busy, proto_err
    );

    modport slave (
        input  mem_tile_addr, mem_tile_read_req, mem_tile_write_req,
               mem_tile_wr_data_wide, mem_tile_config_srf,
        output req_ready, mem_tile_ack, mem_tile_rd_data_wide, busy, proto_err
    );
endinterface

// File: rtl/mem_tile_l2_bank.sv
// mem_tile_l2_bank
// One NUCA L2 bank answering D-tile line reads/writes. Requests are queued
// in a small FIFO and served in order, each after a fixed latency
// (ACCESS_LAT in cache mode, SRF_LAT in scratchpad mode).
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : mem_tile_l2_bank_if slave modport (request, ack, read data,
//           req_ready, busy, proto_err)
module mem_tile_l2_bank #(
    parameter int DEPTH      = 256,
    parameter int ACCESS_LAT = 4,
    parameter int SRF_LAT    = 1,
    parameter int FIFO_DEPTH = 4
) (
    input logic              clk,
    input logic              rst_n,
    mem_tile_l2_bank_if.slave bus
);
    localparam int IDX_W   = $clog2(DEPTH);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int MAX_LAT = (ACCESS_LAT > SRF_LAT) ? ACCESS_LAT : SRF_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;

    typedef logic [3:0][63:0] line_t;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             is_write;
        line_t            data;
        logic             srf;
    } req_t;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESPOND} state_e;

    // ---------------- request FIFO ----------------
    req_t             fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic             fifo_empty, fifo_full, push, pop;
    req_t             push_entry, head;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] op_idx_q, op_idx_d;
    logic             op_wr_q, op_wr_d;
    line_t            op_data_q, op_data_d;
    logic             ack_q, ack_d;
    line_t            rd_data_q, rd_data_d;
    logic             proto_err_q, proto_err_d;
    logic             mem_we;

    line_t            mem [DEPTH];

    // Address bits outside the line index are deliberately dropped (aliasing).
    logic unused_addr;
    assign unused_addr = ^{bus.mem_tile_addr[31:IDX_W+5], bus.mem_tile_addr[4:0]};

    // Extra pointer MSB distinguishes full from empty.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign push       = (bus.mem_tile_read_req | bus.mem_tile_write_req) & ~fifo_full;
    assign pop        = (state_q == S_IDLE) & ~fifo_empty;

    // A simultaneous read+write is queued as a write.
    always_comb begin
        push_entry          = '0;
        push_entry.idx      = bus.mem_tile_addr[IDX_W+4:5];
        push_entry.is_write = bus.mem_tile_write_req;
        push_entry.data     = bus.mem_tile_wr_data_wide;
        push_entry.srf      = bus.mem_tile_config_srf;
    end

    assign head = fifo_mem[rd_ptr_q[PTR_W-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q + (PTR_W+1)'(push);
        rd_ptr_d = rd_ptr_q + (PTR_W+1)'(pop);
    end

    // FIFO storage carries no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q[PTR_W-1:0]] <= push_entry;
    end

    // ---------------- access FSM ----------------
    // The memory op is performed on the edge that enters RESPOND so the
    // registered ack and read data are visible throughout the RESPOND cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_idx_d    = op_idx_q;
        op_wr_d     = op_wr_q;
        op_data_d   = op_data_q;
        ack_d       = 1'b0;
        rd_data_d   = '0;
        mem_we      = 1'b0;
        proto_err_d = proto_err_q | (bus.mem_tile_read_req & bus.mem_tile_write_req);
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    op_idx_d  = head.idx;
                    op_wr_d   = head.is_write;
                    op_data_d = head.data;
                    cnt_d     = head.srf ? CNT_W'(SRF_LAT - 1) : CNT_W'(ACCESS_LAT - 1);
                    state_d   = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = S_RESPOND;
                    ack_d   = 1'b1;
                    if (op_wr_q) mem_we    = 1'b1;
                    else         rd_data_d = mem[op_idx_q];
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RESPOND: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            op_idx_q    <= '0;
            op_wr_q     <= 1'b0;
            op_data_q   <= '0;
            ack_q       <= 1'b0;
            rd_data_q   <= '0;
            proto_err_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_idx_q    <= op_idx_d;
            op_wr_q     <= op_wr_d;
            op_data_q   <= op_data_d;
            ack_q       <= ack_d;
            rd_data_q   <= rd_data_d;
            proto_err_q <= proto_err_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    // Line storage is not reset; committed writes survive a reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[op_idx_q] <= op_data_q;
    end

    assign bus.req_ready             = ~fifo_full;
    assign bus.mem_tile_ack          = ack_q;
    assign bus.mem_tile_rd_data_wide = rd_data_q;
    assign bus.busy                  = ~fifo_empty | (state_q != S_IDLE);
    assign bus.proto_err             = proto_err_q;
endmodule
